uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
Parametrised UART receive engine. It replaces the fixed 8N1 receive shift register in the USRT datapath. It adds configurable data width, runtime parity and stop-bit modes, 2-flop input synchronisation, 3-sample majority voting, false-start rejection, and parity/framing/break reporting. It sits between the serial pin and the receive FIFO, clocked by the peripheral clock.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
BAUD_W, 16, width of the clocks-per-bit divisor input.

Ports:
i_Pclk  in  1  peripheral clock
i_Reset  in  1  synchronous, active-high reset
i_Enable  in  1  receiver enable
i_Baud  in  BAUD_W  clocks per bit; values below 4 are treated as 4
i_Parity  in  2  0 = none, 1 = even, 2 = odd, 3 = none
i_Two_Stop  in  1  1 = two stop bits checked
i_Rx_Serial  in  1  asynchronous serial line, idle high
o_Data  out  DATA_BITS  received word, LSB first on the line
o_Valid  out  1  one-cycle pulse when a frame completes
o_Parity_Err  out  1  parity mismatch; qualified by o_Valid
o_Frame_Err  out  1  stop bit sampled 0; qualified by o_Valid
o_Break  out  1  all-zero frame including stop; qualified by o_Valid
o_Busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: i_Reset is synchronous and active-high, one clock (i_Pclk). It forces state to IDLE, counters to 0, o_Data to 0, o_Valid/o_Parity_Err/o_Frame_Err/o_Break to 0, both sync flops to 1, and the vote history to 3'b111. Reset mid-frame aborts silently.
- Sync and vote: the line passes through 2 flops (sync). A 3-bit history register shifts in the sync output every cycle. vote = majority of the history bits.
- Config latch: on the IDLE->START transition, i_Baud (clamped to a minimum of 4), i_Parity and i_Two_Stop are latched. Changes mid-frame have no effect.
- Bit timing: the bit counter runs 0..B-1, where B is the latched baud. Data, parity and stop bits are sampled when count == B-1, and the counter then wraps to 0. The start bit is sampled at count == (B-1)>>1.
- IDLE: when i_Enable=1 and sync output = 0, go to START with the counter at 0.
- START: at the mid sample, vote=0 -> DATA with the counter cleared. vote=1 -> false start; return to IDLE with no output.
- DATA: vote is shifted in at the MSB and the register shifts right. After DATA_BITS samples, go to PARITY if parity is enabled, otherwise go to STOP.
- PARITY: store the sampled bit. Expected parity is the XOR of the data bits, inverted for odd mode. Set an internal mismatch flag if the sampled bit differs.
- STOP: sample stop bit 1. If i_Two_Stop=1, also sample stop bit 2 one bit period later. Frame error = any sampled stop bit equal to 0.
- DONE: on the cycle after the final stop sample:
  - o_Valid=1 for exactly one cycle.
  - o_Data is loaded from the shift register and holds until the next valid frame.
  - The three error flags are updated and hold until the next o_Valid.
  - o_Break=1 when all data bits, the parity bit (if enabled) and the first stop bit are 0; o_Frame_Err=1 in that case too.
- Exit from DONE: no frame error -> IDLE. Frame error -> WAIT_HIGH, which stays until vote=1, then goes to IDLE. This prevents re-triggering during a break.
- i_Enable=0 in any state except DONE: return to IDLE next cycle with no o_Valid. Register contents are kept.
- Frame latency: o_Valid follows the start edge on the pin by roughly 2 + (B-1)/2 + B·(DATA_BITS + P + S) + 1 cycles, where P = 1 if parity is enabled and S = number of stop bits.
- Back-to-back frames: a start edge detected in the IDLE cycle right after DONE is accepted. Frames must be contiguous at the nominal baud.

Test Plan:
- 8N1, B=16, send 0xA5 -> one o_Valid pulse, o_Data=0xA5, all error flags 0, o_Busy low afterwards.
- DATA_BITS=7, even parity, B=10, send 0x41 with a wrong parity bit -> o_Data=0x41, o_Parity_Err=1, o_Frame_Err=0.
- Stop bit driven 0 for 0x3C, then line held low 40 cycles -> o_Frame_Err=1; state stays in WAIT_HIGH until the line rises; no second o_Valid.
- Line low for 3 cycles only, B=16 -> o_Busy pulses, no o_Valid, return to IDLE.
- Break (line low for 12 bit times), 8N1 -> o_Valid with o_Data=0x00, o_Break=1, o_Frame_Err=1.
- 1-cycle glitch at the centre of data bit 3 of 0xFF, odd parity, two stop bits -> o_Data=0xFF, no errors. Dropping i_Enable at bit 5 of a second frame -> no o_Valid.

Source files
------------

// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
// Parametrised UART receive engine sitting between the serial pin and the
// receive FIFO. The line is double-flopped and majority-voted over three
// samples. False starts are rejected. Data width, parity mode and stop-bit
// count are configurable, and parity, framing and break errors are reported.
//
// Parameters:
//   DATA_BITS    data bits per frame (5..9)
//   BAUD_W       width of the clocks-per-bit divisor
// Ports:
//   i_Pclk       peripheral clock
//   i_Reset      synchronous, active-high reset
//   i_Enable     receiver enable
//   i_Baud       clocks per bit (values below 4 behave as 4)
//   i_Parity     0/3 = none, 1 = even, 2 = odd
//   i_Two_Stop   1 = two stop bits are checked
//   i_Rx_Serial  asynchronous serial line, idle high
//   o_Data       received word, first line bit in the LSB
//   o_Valid      one-cycle pulse when a frame completes
//   o_Parity_Err parity mismatch, qualified by o_Valid
//   o_Frame_Err  a stop bit sampled 0, qualified by o_Valid
//   o_Break      all-zero frame including the first stop bit
//   o_Busy       high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_frame #(
   parameter int DATA_BITS = 8,
   parameter int BAUD_W    = 16
) (
   input  logic                 i_Pclk,
   input  logic                 i_Reset,
   input  logic                 i_Enable,
   input  logic [BAUD_W-1:0]    i_Baud,
   input  logic [1:0]           i_Parity,
   input  logic                 i_Two_Stop,
   input  logic                 i_Rx_Serial,
   output logic [DATA_BITS-1:0] o_Data,
   output logic                 o_Valid,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Break,
   output logic                 o_Busy
);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH
   } state_t;

   state_t state, state_nxt;

   logic                 sync_0, sync_1;
   logic [2:0]           hist;
   logic                 vote;
   logic [BAUD_W-1:0]    baud_clamped, baud_lat, count;
   logic [1:0]           parity_lat;
   logic                 two_stop_lat;
   logic [3:0]           bit_cnt;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit, par_mismatch, stop1_bit, stop_zero;
   logic                 mid_tick, bit_tick, par_en, last_data, last_stop;
   logic                 stop1_now, frame_err_now, break_now;

   assign vote          = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
   assign baud_clamped  = (i_Baud < BAUD_W'(4)) ? BAUD_W'(4) : i_Baud;
   assign bit_tick      = (count == (baud_lat - BAUD_W'(1)));
   assign mid_tick      = (count == ((baud_lat - BAUD_W'(1)) >> 1));
   assign par_en        = (parity_lat == 2'd1) || (parity_lat == 2'd2);
   assign last_data     = (bit_cnt == 4'(DATA_BITS - 1));
   assign last_stop     = (stop_idx == two_stop_lat);

   // The final stop sample is folded in combinationally so the flags loaded
   // on entry to DONE already include it; stop bit 1 is either being sampled
   // now or was captured one bit period earlier.
   assign stop1_now     = stop_idx ? stop1_bit : vote;
   assign frame_err_now = stop_zero | ~vote;
   assign break_now     = (shreg == '0) && !(par_en && par_bit) && !stop1_now;

   assign o_Busy  = (state != IDLE);
   assign o_Valid = (state == DONE);

   // State register.
   always_ff @(posedge i_Pclk) begin
      if (i_Reset) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state decode. Dropping the enable abandons any frame except one
   // already in DONE, so a completed frame is always reported. After a
   // framing error we park in WAIT_HIGH so a held-low break line cannot
   // immediately look like a new start bit.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (i_Enable && !sync_1) state_nxt = START;
         START:     if (mid_tick) state_nxt = vote ? IDLE : DATA;
         DATA:      if (bit_tick && last_data) state_nxt = par_en ? PARITY : STOP;
         PARITY:    if (bit_tick) state_nxt = STOP;
         STOP:      if (bit_tick && last_stop) state_nxt = DONE;
         DONE:      state_nxt = o_Frame_Err ? WAIT_HIGH : IDLE;
         WAIT_HIGH: if (vote) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
      if (!i_Enable && (state != DONE)) state_nxt = IDLE;
   end

   // Datapath: synchroniser, vote history, bit timing, shift register,
   // error tracking and output registers. Configuration is captured only
   // when a start edge is accepted so mid-frame changes are ignored.
   always_ff @(posedge i_Pclk) begin
      if (i_Reset) begin
         sync_0       <= 1'b1;
         sync_1       <= 1'b1;
         hist         <= 3'b111;
         count        <= '0;
         bit_cnt      <= '0;
         stop_idx     <= 1'b0;
         baud_lat     <= BAUD_W'(4);
         parity_lat   <= 2'd0;
         two_stop_lat <= 1'b0;
         shreg        <= '0;
         par_bit      <= 1'b0;
         par_mismatch <= 1'b0;
         stop1_bit    <= 1'b1;
         stop_zero    <= 1'b0;
         o_Data       <= '0;
         o_Parity_Err <= 1'b0;
         o_Frame_Err  <= 1'b0;
         o_Break      <= 1'b0;
      end else begin
         sync_0 <= i_Rx_Serial;
         sync_1 <= sync_0;
         hist   <= {hist[1:0], sync_1};
         case (state)
            IDLE: begin
               if (state_nxt == START) begin
                  count        <= '0;
                  bit_cnt      <= '0;
                  stop_idx     <= 1'b0;
                  par_bit      <= 1'b0;
                  par_mismatch <= 1'b0;
                  stop_zero    <= 1'b0;
                  baud_lat     <= baud_clamped;
                  parity_lat   <= i_Parity;
                  two_stop_lat <= i_Two_Stop;
               end
            end
            START: begin
               count <= (state_nxt == DATA) ? '0 : count + BAUD_W'(1);
            end
            DATA: begin
               if (i_Enable) begin
                  count <= bit_tick ? '0 : count + BAUD_W'(1);
                  if (bit_tick) begin
                     shreg   <= {vote, shreg[DATA_BITS-1:1]};
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            end
            PARITY: begin
               if (i_Enable) begin
                  count <= bit_tick ? '0 : count + BAUD_W'(1);
                  if (bit_tick) begin
                     par_bit      <= vote;
                     par_mismatch <= vote ^ (^shreg) ^ (parity_lat == 2'd2);
                  end
               end
            end
            STOP: begin
               if (i_Enable) begin
                  count <= bit_tick ? '0 : count + BAUD_W'(1);
                  if (bit_tick) begin
                     stop_idx  <= 1'b1;
                     stop_zero <= frame_err_now;
                     if (!stop_idx) stop1_bit <= vote;
                     if (last_stop) begin
                        o_Data       <= shreg;
                        o_Parity_Err <= par_mismatch;
                        o_Frame_Err  <= frame_err_now;
                        o_Break      <= break_now;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
// Directed bench for uart_rx_frame. An 8-bit instance covers the main
// frame formats, false start, stop-bit errors, break, glitch rejection,
// divisor clamping and enable drop. A 7-bit instance covers parity errors.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

   logic        clk;
   logic        reset;
   logic        enable8, twoStop8, rx8;
   logic [15:0] baud8;
   logic [1:0]  parity8;
   logic [7:0]  data8;
   logic        valid8, pe8, fe8, brk8, busy8;
   logic        enable7, twoStop7, rx7;
   logic [15:0] baud7;
   logic [1:0]  parity7;
   logic [6:0]  data7;
   logic        valid7, pe7, fe7, brk7, busy7;

   int total = 0;
   int bad   = 0;

   int         validCount8 = 0;
   logic [7:0] capData8;
   logic       capPe8, capFe8, capBrk8;
   int         validCount7 = 0;
   logic [6:0] capData7;
   logic       capPe7, capFe7, capBrk7;

   uart_rx_frame #(.DATA_BITS(8), .BAUD_W(16)) dut8 (
      .i_Pclk(clk), .i_Reset(reset), .i_Enable(enable8), .i_Baud(baud8),
      .i_Parity(parity8), .i_Two_Stop(twoStop8), .i_Rx_Serial(rx8),
      .o_Data(data8), .o_Valid(valid8), .o_Parity_Err(pe8),
      .o_Frame_Err(fe8), .o_Break(brk8), .o_Busy(busy8)
   );

   uart_rx_frame #(.DATA_BITS(7), .BAUD_W(16)) dut7 (
      .i_Pclk(clk), .i_Reset(reset), .i_Enable(enable7), .i_Baud(baud7),
      .i_Parity(parity7), .i_Two_Stop(twoStop7), .i_Rx_Serial(rx7),
      .o_Data(data7), .o_Valid(valid7), .o_Parity_Err(pe7),
      .o_Frame_Err(fe7), .o_Break(brk7), .o_Busy(busy7)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count valid pulses on each instance and capture what came with them.
   always @(negedge clk) begin
      if (valid8) begin
         validCount8 <= validCount8 + 1;
         capData8    <= data8;
         capPe8      <= pe8;
         capFe8      <= fe8;
         capBrk8     <= brk8;
      end
      if (valid7) begin
         validCount7 <= validCount7 + 1;
         capData7    <= data7;
         capPe7      <= pe7;
         capFe7      <= fe7;
         capBrk7     <= brk7;
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Compare one observed value with its expected value and tally it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive a frame LSB first (start bit in bit 0), each bit held for cyc
   // clocks. Optionally pull one mid-bit clock low or drop the 8-bit
   // instance's enable at the start of a given frame bit.
   task automatic applyStimulus(input logic [15:0] frame, input int nbits,
                                input int cyc, input int sel,
                                input int glitchBit, input int dropBit);
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < cyc; c++) begin
            logic v;
            @(negedge clk);
            v = frame[b];
            if (b == glitchBit && c == cyc / 2) v = 1'b0;
            if (b == dropBit && c == 0) enable8 = 1'b0;
            if (sel == 0) rx8 = v;
            else          rx7 = v;
         end
      end
   endtask

   // Directed sequence.
   initial begin
      int  v0;
      int  v7;
      logic busySeen;

      reset = 1'b1;
      enable8 = 1'b1; baud8 = 16'd16; parity8 = 2'd0; twoStop8 = 1'b0; rx8 = 1'b1;
      enable7 = 1'b0; baud7 = 16'd10; parity7 = 2'd1; twoStop7 = 1'b0; rx7 = 1'b1;
      waitCycles(3);
      reset = 1'b0;
      waitCycles(1);
      checkOutput("rst_valid", valid8, 1'b0);
      checkOutput("rst_data",  data8, 8'h00);
      checkOutput("rst_perr",  pe8, 1'b0);
      checkOutput("rst_ferr",  fe8, 1'b0);
      checkOutput("rst_break", brk8, 1'b0);
      checkOutput("rst_busy",  busy8, 1'b0);
      waitCycles(5);

      // 8N1 0xA5 at 16 clocks per bit.
      $display("[TB] 8N1 0xA5");
      v0 = validCount8;
      applyStimulus({6'b0, 1'b1, 8'hA5, 1'b0}, 10, 16, 0, -1, -1);
      rx8 = 1'b1;
      waitCycles(20);
      checkOutput("a5_count", validCount8 - v0, 1);
      checkOutput("a5_data",  capData8, 8'hA5);
      checkOutput("a5_perr",  capPe8, 1'b0);
      checkOutput("a5_ferr",  capFe8, 1'b0);
      checkOutput("a5_break", capBrk8, 1'b0);
      checkOutput("a5_busy",  busy8, 1'b0);

      // 7E1 0x41 with the parity bit inverted (correct even parity is 0).
      $display("[TB] 7E1 0x41 bad parity");
      enable7 = 1'b1;
      waitCycles(4);
      v7 = validCount7;
      applyStimulus({6'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 10, 10, 1, -1, -1);
      rx7 = 1'b1;
      waitCycles(20);
      checkOutput("p7_count", validCount7 - v7, 1);
      checkOutput("p7_data",  capData7, 7'h41);
      checkOutput("p7_perr",  capPe7, 1'b1);
      checkOutput("p7_ferr",  capFe7, 1'b0);

      // Three-clock low pulse must be rejected as a false start.
      $display("[TB] false start");
      v0 = validCount8;
      busySeen = 1'b0;
      @(negedge clk);
      rx8 = 1'b0;
      waitCycles(3);
      rx8 = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy8) busySeen = 1'b1;
      end
      checkOutput("fs_busyseen", busySeen, 1'b1);
      checkOutput("fs_count", validCount8 - v0, 0);
      checkOutput("fs_busy",  busy8, 1'b0);

      // Divisor below the minimum behaves as 4 clocks per bit.
      $display("[TB] baud clamp");
      baud8 = 16'd2;
      v0 = validCount8;
      applyStimulus({6'b0, 1'b1, 8'h5A, 1'b0}, 10, 4, 0, -1, -1);
      rx8 = 1'b1;
      waitCycles(12);
      checkOutput("cl_count", validCount8 - v0, 1);
      checkOutput("cl_data",  capData8, 8'h5A);
      baud8 = 16'd16;

      // 0x3C with a zero stop bit, line then held low.
      $display("[TB] stop bit zero");
      v0 = validCount8;
      applyStimulus({6'b0, 1'b0, 8'h3C, 1'b0}, 10, 16, 0, -1, -1);
      waitCycles(40);
      checkOutput("sz_busy_low", busy8, 1'b1);
      rx8 = 1'b1;
      waitCycles(10);
      checkOutput("sz_count", validCount8 - v0, 1);
      checkOutput("sz_data",  capData8, 8'h3C);
      checkOutput("sz_ferr",  capFe8, 1'b1);
      checkOutput("sz_break", capBrk8, 1'b0);
      checkOutput("sz_busy",  busy8, 1'b0);

      // Break: twelve bit times low.
      $display("[TB] break");
      v0 = validCount8;
      @(negedge clk);
      rx8 = 1'b0;
      waitCycles(192);
      rx8 = 1'b1;
      waitCycles(10);
      checkOutput("bk_count", validCount8 - v0, 1);
      checkOutput("bk_data",  capData8, 8'h00);
      checkOutput("bk_break", capBrk8, 1'b1);
      checkOutput("bk_ferr",  capFe8, 1'b1);
      checkOutput("bk_perr",  capPe8, 1'b0);
      checkOutput("bk_busy",  busy8, 1'b0);

      // Reset clears the held error flags.
      reset = 1'b1;
      waitCycles(2);
      checkOutput("rr_break", brk8, 1'b0);
      checkOutput("rr_ferr",  fe8, 1'b0);
      reset = 1'b0;
      waitCycles(4);

      // 0xFF, odd parity (bit = 1), two stops, glitch in data bit 3.
      $display("[TB] glitch 8O2");
      parity8 = 2'd2; twoStop8 = 1'b1; baud8 = 16'd8;
      v0 = validCount8;
      applyStimulus({4'b0, 2'b11, 1'b1, 8'hFF, 1'b0}, 12, 8, 0, 4, -1);
      rx8 = 1'b1;
      waitCycles(20);
      checkOutput("gl_count", validCount8 - v0, 1);
      checkOutput("gl_data",  capData8, 8'hFF);
      checkOutput("gl_perr",  capPe8, 1'b0);
      checkOutput("gl_ferr",  capFe8, 1'b0);

      // Second frame 0x0F abandoned by dropping enable at data bit 5.
      $display("[TB] enable drop");
      v0 = validCount8;
      applyStimulus({4'b0, 2'b11, 1'b1, 8'h0F, 1'b0}, 12, 8, 0, -1, 6);
      rx8 = 1'b1;
      waitCycles(20);
      enable8 = 1'b1;
      waitCycles(10);
      checkOutput("ed_count", validCount8 - v0, 0);
      checkOutput("ed_busy",  busy8, 1'b0);
      checkOutput("ed_hold",  data8, 8'hFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
